// File: rtl/tile_raster_collector_pkg.sv
// Shared constants and state encodings for the tile raster collector.
// Latency: none (package only).
// Backpressure: n/a.
package tile_pkg;

  localparam int PIX_W         = 8;
  localparam int TILE_W        = 12;
  localparam int TILE_H        = 3;
  localparam int TILES_PER_ROW = 53;
  localparam int BANDS         = 160;
  localparam int ROW_BITS      = PIX_W * TILE_W;     // 96
  localparam int TILE_BITS     = ROW_BITS * TILE_H;  // 288

  localparam int COL_W  = 6;
  localparam int BAND_W = 8;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(TILES_PER_ROW - 1);
  localparam logic [1:0]        LAST_ROW  = 2'(TILE_H - 1);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(BANDS - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;
  typedef enum logic       {IDLE, DRAIN}                     rd_state_e;

endpackage

// File: rtl/tile_raster_collector_band_bank_ram.sv
// One band of storage: 3 rows x 53 columns x 96 bits; all 3 rows of a tile written together.
// Latency: write lands on the clock edge; read is combinational from (row, col).
// Backpressure: none, the collector decides when writes happen.
// Ports: clk_i, we_i/wcol_i/wdata_i (tile write), rrow_i/rcol_i -> rdata_o (row read).
module band_bank_ram
  import tile_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [COL_W-1:0]     wcol_i,
  input  logic [TILE_BITS-1:0] wdata_i,
  input  logic [1:0]           rrow_i,
  input  logic [COL_W-1:0]     rcol_i,
  output logic [ROW_BITS-1:0]  rdata_o
);

  logic [ROW_BITS-1:0] row0_q [TILES_PER_ROW];
  logic [ROW_BITS-1:0] row1_q [TILES_PER_ROW];
  logic [ROW_BITS-1:0] row2_q [TILES_PER_ROW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      row0_q[wcol_i] <= wdata_i[TILE_BITS-1            -: ROW_BITS];
      row1_q[wcol_i] <= wdata_i[TILE_BITS-1-ROW_BITS   -: ROW_BITS];
      row2_q[wcol_i] <= wdata_i[ROW_BITS-1             -: ROW_BITS];
    end
  end

  always_comb begin
    case (rrow_i)
      2'd0:    rdata_o = row0_q[rcol_i];
      2'd1:    rdata_o = row1_q[rcol_i];
      default: rdata_o = row2_q[rcol_i];
    endcase
  end

endmodule

// File: rtl/tile_raster_collector.sv
// Collects 3x12 tiles of a band into ping-pong banks and re-emits them in raster order, 12 px/beat.
// Latency: first beat valid 2 cycles after the band's last tile; then 1 beat/cycle.
// Backpressure: valid/ready on the output; tiles hitting a busy bank are dropped and flag overflow.
// Ports: clk, rst_n, in_valid/in_pixels (tiles), out_valid/out_ready/out_pixels/out_last/
//        out_frame_end (raster beats), overflow (sticky drop flag).
module tile_raster_collector
  import tile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [TILE_BITS-1:0] in_pixels,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_BITS-1:0]  out_pixels,
  output logic                 out_last,
  output logic                 out_frame_end,
  output logic                 overflow
);

  bank_state_e         bank_q [2];
  bank_state_e         bank_d [2];
  logic                wr_bank_q, wr_bank_d;
  logic [COL_W-1:0]    wr_col_q, wr_col_d;
  logic                overflow_q, overflow_d;
  rd_state_e           state_q, state_d;
  logic                rd_bank_q, rd_bank_d;
  logic [1:0]          rd_row_q, rd_row_d;
  logic [COL_W-1:0]    rd_col_q, rd_col_d;
  logic [BAND_W-1:0]   rd_band_q, rd_band_d;
  logic                out_valid_q, out_valid_d;
  logic [ROW_BITS-1:0] out_pixels_q, out_pixels_d;
  logic                out_last_q, out_last_d;
  logic                out_fe_q, out_fe_d;
  logic                wr_en, load;
  logic [ROW_BITS-1:0] rdata0, rdata1;

  // Both banks are read at the next-beat pointer; the output register picks one.
  band_bank_ram u_bank0 (
    .clk_i   (clk),
    .we_i    (wr_en && !wr_bank_q),
    .wcol_i  (wr_col_q),
    .wdata_i (in_pixels),
    .rrow_i  (rd_row_d),
    .rcol_i  (rd_col_d),
    .rdata_o (rdata0)
  );

  band_bank_ram u_bank1 (
    .clk_i   (clk),
    .we_i    (wr_en && wr_bank_q),
    .wcol_i  (wr_col_q),
    .wdata_i (in_pixels),
    .rrow_i  (rd_row_d),
    .rcol_i  (rd_col_d),
    .rdata_o (rdata1)
  );

  always_comb begin
    bank_d       = bank_q;
    wr_bank_d    = wr_bank_q;
    wr_col_d     = wr_col_q;
    overflow_d   = overflow_q;
    wr_en        = 1'b0;
    state_d      = state_q;
    rd_bank_d    = rd_bank_q;
    rd_row_d     = rd_row_q;
    rd_col_d     = rd_col_q;
    rd_band_d    = rd_band_q;
    out_valid_d  = out_valid_q;
    out_pixels_d = out_pixels_q;
    out_last_d   = out_last_q;
    out_fe_d     = out_fe_q;
    load         = 1'b0;

    // Write side. Pointers advance even on a dropped tile so later bands stay aligned.
    // The write and read sides never change the same bank in the same cycle: the write
    // side only touches EMPTY/FILLING banks, the read side only FULL/DRAINING ones.
    if (in_valid) begin
      if (bank_q[wr_bank_q] == EMPTY || bank_q[wr_bank_q] == FILLING) begin
        wr_en             = 1'b1;
        bank_d[wr_bank_q] = (wr_col_q == LAST_COL) ? FULL : FILLING;
      end else begin
        overflow_d = 1'b1;
      end
      if (wr_col_q == LAST_COL) begin
        wr_col_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end

    // Read side: pointers name the beat currently held in the output register.
    case (state_q)
      IDLE: begin
        if (bank_q[rd_bank_q] == FULL) begin
          bank_d[rd_bank_q] = DRAINING;
          rd_row_d          = '0;
          rd_col_d          = '0;
          state_d           = DRAIN;
          load              = 1'b1;
        end
      end
      default: begin
        if (out_ready) begin
          if (rd_row_q == LAST_ROW && rd_col_q == LAST_COL) begin
            bank_d[rd_bank_q] = EMPTY;
            rd_bank_d         = ~rd_bank_q;
            rd_band_d         = (rd_band_q == LAST_BAND) ? '0 : rd_band_q + BAND_W'(1);
            rd_row_d          = '0;
            rd_col_d          = '0;
            // Chain straight into the other bank when it is already waiting.
            if (bank_q[~rd_bank_q] == FULL) begin
              bank_d[~rd_bank_q] = DRAINING;
              load               = 1'b1;
            end else begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
            end
          end else begin
            load = 1'b1;
            if (rd_col_q == LAST_COL) begin
              rd_col_d = '0;
              rd_row_d = rd_row_q + 2'd1;
            end else begin
              rd_col_d = rd_col_q + COL_W'(1);
            end
          end
        end
      end
    endcase

    if (load) begin
      out_valid_d  = 1'b1;
      out_pixels_d = rd_bank_d ? rdata1 : rdata0;
      out_last_d   = (rd_col_d == LAST_COL);
      out_fe_d     = (rd_col_d == LAST_COL) && (rd_row_d == LAST_ROW) && (rd_band_d == LAST_BAND);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q[0]    <= EMPTY;
      bank_q[1]    <= EMPTY;
      wr_bank_q    <= 1'b0;
      wr_col_q     <= '0;
      overflow_q   <= 1'b0;
      state_q      <= IDLE;
      rd_bank_q    <= 1'b0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      rd_band_q    <= '0;
      out_valid_q  <= 1'b0;
      out_pixels_q <= '0;
      out_last_q   <= 1'b0;
      out_fe_q     <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      wr_bank_q    <= wr_bank_d;
      wr_col_q     <= wr_col_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      rd_bank_q    <= rd_bank_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      rd_band_q    <= rd_band_d;
      out_valid_q  <= out_valid_d;
      out_pixels_q <= out_pixels_d;
      out_last_q   <= out_last_d;
      out_fe_q     <= out_fe_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pixels    = out_pixels_q;
  assign out_last      = out_last_q;
  assign out_frame_end = out_fe_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_tile_raster_collector.sv
// Bench for tile_raster_collector: expected raster beats queued per band, compared as captured.
// Latency: n/a.
// Backpressure: out_ready driven always-high, random, or held low per scenario.
module tb_tile_raster_collector;

  typedef struct packed {
    logic [95:0] pix;
    logic        last;
    logic        fe;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [287:0] in_pixels = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [95:0]  out_pixels;
  logic         out_last;
  logic         out_frame_end;
  logic         overflow;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int exp_rd_band = 0;
  int got = 0;
  int stall_breaks = 0;
  int first_vld_cyc = -1;
  int last_in_cyc = 0;
  beat_t exp_q[$];
  beat_t act_q[$];

  tile_raster_collector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_pixels     (in_pixels),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pixels    (out_pixels),
    .out_last      (out_last),
    .out_frame_end (out_frame_end),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] row_val(input int seed, input int r, input int k);
    logic [7:0] v;
    v = 8'((seed * 7 + r * 53 + k) % 256);
    return {12{v}};
  endfunction

  // Queue the 159 raster beats one band should produce.
  task automatic push_exp(input int seed);
    beat_t b;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 53; k++) begin
        b.pix  = row_val(seed, r, k);
        b.last = (k == 52);
        b.fe   = (k == 52) && (r == 2) && (exp_rd_band == 159);
        exp_q.push_back(b);
      end
    end
    exp_rd_band = (exp_rd_band + 1) % 160;
  endtask

  task automatic drive_tile(input int seed, input int k);
    in_valid    = 1'b1;
    in_pixels   = {row_val(seed, 0, k), row_val(seed, 1, k), row_val(seed, 2, k)};
    last_in_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_bands(input int seed0, input int nb, input int gap);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 53; k++) begin
        drive_tile(seed0 + b, k);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
  endtask

  // Records transferred beats; mode 0 = ready high, mode 1 = random ready with a 10-cycle stall.
  task automatic capture(input int n, input int mode, input int budget);
    int    cycles;
    int    hold_cnt;
    logic  stalled;
    logic  stall_done;
    beat_t held;
    beat_t cur;
    cycles = 0; hold_cnt = 0; stalled = 1'b0; stall_done = 1'b0; held = '0;
    got = 0; stall_breaks = 0; first_vld_cyc = -1;
    out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    while (got < n && cycles < budget) begin
      @(negedge clk);
      cycles++;
      cur = {out_pixels, out_last, out_frame_end};
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (stalled && (!out_valid || cur != held)) stall_breaks++;
      stalled = out_valid && !out_ready;
      held = cur;
      if (out_valid && out_ready) begin
        act_q.push_back(cur);
        got++;
      end
      @(posedge clk); #1;
      if (mode == 1) begin
        if (got == 30 && !stall_done) begin
          hold_cnt = 10;
          stall_done = 1'b1;
        end
        if (hold_cnt > 0) begin
          out_ready = 1'b0;
          hold_cnt--;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    act_q.delete();
    exp_rd_band = 0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if ({out_valid, out_pixels, out_last, out_frame_end, overflow} !== 100'b0)
      $display("FAIL reset_state got v=%b pix=%h l=%b fe=%b ovf=%b want all 0",
               out_valid, out_pixels, out_last, out_frame_end, overflow);
    else pass_cnt++;
  endtask

  task automatic test_band_order();
    int lasts = 0;
    beat_t e, a;
    do_reset();
    push_exp(0);
    fork
      drive_bands(0, 1, 0);
      capture(159, 0, 400);
    join
    chk_cnt++;
    if (got !== 159) $display("FAIL order_count got %0d want 159", got); else pass_cnt++;
    chk_cnt++;
    if (first_vld_cyc - last_in_cyc !== 2)
      $display("FAIL order_latency got %0d want 2", first_vld_cyc - last_in_cyc);
    else pass_cnt++;
    for (int i = 0; act_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      if (a.last) lasts++;
      chk_cnt++;
      if (a !== e) $display("FAIL order_beat%0d got %h/%b/%b want %h/%b/%b", i, a.pix, a.last, a.fe, e.pix, e.last, e.fe);
      else pass_cnt++;
    end
    chk_cnt++;
    if (lasts !== 3) $display("FAIL order_last_count got %0d want 3", lasts); else pass_cnt++;
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL order_overflow got %b want 0", overflow); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    beat_t e, a;
    do_reset();
    push_exp(3);
    fork
      drive_bands(3, 1, 0);
      capture(159, 1, 1500);
    join
    chk_cnt++;
    if (got !== 159) $display("FAIL bp_count got %0d want 159", got); else pass_cnt++;
    chk_cnt++;
    if (stall_breaks !== 0) $display("FAIL bp_stable got %0d breaks want 0", stall_breaks); else pass_cnt++;
    for (int i = 0; act_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      chk_cnt++;
      if (a !== e) $display("FAIL bp_beat%0d got %h/%b/%b want %h/%b/%b", i, a.pix, a.last, a.fe, e.pix, e.last, e.fe);
      else pass_cnt++;
    end
  endtask

  task automatic test_ping_pong();
    beat_t e, a;
    do_reset();
    push_exp(10);
    push_exp(11);
    fork
      drive_bands(10, 2, 0);
      capture(318, 0, 600);
    join
    chk_cnt++;
    if (got !== 318) $display("FAIL pp_count got %0d want 318", got); else pass_cnt++;
    for (int i = 0; act_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      chk_cnt++;
      if (a !== e) $display("FAIL pp_beat%0d got %h/%b/%b want %h/%b/%b", i, a.pix, a.last, a.fe, e.pix, e.last, e.fe);
      else pass_cnt++;
    end
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL pp_overflow got %b want 0", overflow); else pass_cnt++;
  endtask

  task automatic test_overflow();
    beat_t e, a;
    do_reset();
    push_exp(20);
    push_exp(21);
    out_ready = 1'b0;
    drive_bands(20, 2, 0);
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_before got %b want 0", overflow); else pass_cnt++;
    drive_tile(22, 0);
    chk_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_rise got %b want 1", overflow); else pass_cnt++;
    for (int k = 1; k < 53; k++) drive_tile(22, k);
    chk_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow); else pass_cnt++;
    capture(318, 0, 600);
    chk_cnt++;
    if (got !== 318) $display("FAIL ovf_count got %0d want 318", got); else pass_cnt++;
    for (int i = 0; act_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      chk_cnt++;
      if (a !== e) $display("FAIL ovf_beat%0d got %h/%b/%b want %h/%b/%b", i, a.pix, a.last, a.fe, e.pix, e.last, e.fe);
      else pass_cnt++;
    end
    capture(1, 0, 40);
    chk_cnt++;
    if (got !== 0) $display("FAIL ovf_band3_absent got %0d beats want 0", got); else pass_cnt++;
    chk_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_end got %b want 1", overflow); else pass_cnt++;
  endtask

  task automatic test_frame_end();
    int    fe_seen = 0;
    int    fe_idx = -1;
    beat_t e, a;
    do_reset();
    for (int b = 0; b < 161; b++) push_exp(100 + b);
    fork
      drive_bands(100, 161, 2);
      capture(161 * 159, 0, 30000);
    join
    chk_cnt++;
    if (got !== 161 * 159) $display("FAIL fe_count got %0d want %0d", got, 161 * 159); else pass_cnt++;
    for (int i = 0; act_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      if (a.fe) begin fe_seen++; fe_idx = i; end
      chk_cnt++;
      if (a !== e) $display("FAIL fe_beat%0d got %h/%b/%b want %h/%b/%b", i, a.pix, a.last, a.fe, e.pix, e.last, e.fe);
      else pass_cnt++;
    end
    chk_cnt++;
    if (fe_seen !== 1 || fe_idx !== 160 * 159 - 1)
      $display("FAIL fe_single got %0d at %0d want 1 at %0d", fe_seen, fe_idx, 160 * 159 - 1);
    else pass_cnt++;
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL fe_overflow got %b want 0", overflow); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    beat_t e, a;
    do_reset();
    push_exp(40);
    fork
      drive_bands(40, 1, 0);
      capture(70, 0, 400);
    join
    for (int i = 0; act_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      chk_cnt++;
      if (a !== e) $display("FAIL rst_pre_beat%0d got %h want %h", i, a.pix, e.pix);
      else pass_cnt++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_cnt++;
    if ({out_valid, out_pixels, out_last, out_frame_end, overflow} !== 100'b0)
      $display("FAIL rst_mid_state got v=%b pix=%h l=%b fe=%b ovf=%b want all 0",
               out_valid, out_pixels, out_last, out_frame_end, overflow);
    else pass_cnt++;
    exp_q.delete();
    act_q.delete();
    exp_rd_band = 0;
    capture(1, 0, 30);
    chk_cnt++;
    if (got !== 0) $display("FAIL rst_quiet got %0d beats want 0", got); else pass_cnt++;
    push_exp(41);
    fork
      drive_bands(41, 1, 0);
      capture(159, 0, 400);
    join
    chk_cnt++;
    if (got !== 159) $display("FAIL rst_fresh_count got %0d want 159", got); else pass_cnt++;
    for (int i = 0; act_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      chk_cnt++;
      if (a !== e) $display("FAIL rst_fresh_beat%0d got %h/%b/%b want %h/%b/%b", i, a.pix, a.last, a.fe, e.pix, e.last, e.fe);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_band_order();
    test_backpressure();
    test_ping_pong();
    test_overflow();
    test_frame_end();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tile_raster_collector.md
Name: tile_raster_collector

Overview:
- Sits directly downstream of `top`, the 3x3 filter core.
- `top` emits one 3-row x 12-column output tile per `valid` cycle. Tiles walk left-to-right across a 3-row band (53 tiles), then move down to the next band (160 bands per 636x480 frame).
- This block collects each band into a ping-pong buffer and re-emits it in raster order, 12 pixels per beat, over a ready/valid interface to the frame writer.

Parameters:
- PIX_W, 8, bits per pixel
- TILE_W, 12, pixels per tile row
- TILE_H, 3, rows per tile/band
- TILES_PER_ROW, 53, tiles per band (53*12 = 636)
- BANDS, 160, bands per frame (160*3 = 480)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  tile present (driven by `top` `valid`)
- in_pixels  in  288  tile data
  - [287:192] = row 0, [191:96] = row 1, [95:0] = row 2.
  - Within each 96-bit row, the leftmost pixel is in the MSB byte.
- out_valid  out  1  beat available
- out_ready  in  1  sink accepts the beat
- out_pixels  out  96  12 pixels of one raster row, leftmost pixel in the MSB byte
- out_last  out  1  last beat of an image row
- out_frame_end  out  1  last beat of the frame
- overflow  out  1  sticky: an input tile was dropped

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - Reset is synchronous and active-low on `rst_n`.
  - Reset values: out_valid=0, out_pixels=0, out_last=0, out_frame_end=0, overflow=0.
  - Reset also clears both banks to EMPTY and zeroes all pointers and counters.
  - Reset mid-operation discards any partial or full bands; nothing is emitted afterwards until new input arrives.
- Storage: 2 banks x 3 rows x 53 entries x 96 bits.
- Bank state machine (per bank): EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - wr_bank and wr_col (0..52).
  - On in_valid with wr_bank EMPTY or FILLING: store the three 96-bit rows at wr_col. The bank becomes FILLING.
  - At wr_col=52: the bank becomes FULL, wr_col returns to 0 and wr_bank toggles.
- Overflow on the write side:
  - Applies when in_valid arrives and wr_bank is FULL or DRAINING.
  - The tile is dropped and overflow is set (sticky until reset).
  - wr_col and wr_bank still advance so band alignment is kept.
- Read side FSM, IDLE/DRAIN:
  - IDLE -> DRAIN when rd_bank is FULL; rd_bank becomes DRAINING.
  - Traversal order: rd_row 0..2 outer, rd_col 0..52 inner.
- Output registering:
  - out_pixels, out_last and out_frame_end are registered.
  - First out_valid appears 1 cycle after the bank becomes FULL, i.e. 2 cycles after the 53rd tile's in_valid.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_pixels, out_last and out_frame_end must hold stable.
  - out_valid never drops without a transfer, except at reset.
- Pipelining: after a transfer, the next beat is presented the following cycle, giving 1 beat/cycle with out_ready held high.
- out_last = 1 when rd_col=52.
- out_frame_end = 1 when rd_col=52, rd_row=2 and rd_band=BANDS-1.
- End of a band:
  - On the transfer of rd_row=2, rd_col=52: the bank becomes EMPTY on the next edge, rd_bank toggles and rd_band increments (wrapping 159 -> 0).
  - The FSM returns to IDLE, or re-enters DRAIN immediately if the other bank is FULL, with no bubble beyond 1 cycle.
- Simultaneous events:
  - A tile arriving in the same cycle that a bank's final beat transfers still sees that bank as DRAINING, so it overflows.
  - Write and read of different banks in the same cycle are independent.
- Throughput: input may burst 53 tiles back to back. Sustained input must average ≤ 1 tile per 3 cycles, otherwise overflow occurs.

Decomposition:
- Shared package `tile_pkg`:
  - constants PIX_W, TILE_W, TILE_H, TILES_PER_ROW, BANDS, ROW_BITS = 96, TILE_BITS = 288;
  - bank-state enum {EMPTY, FILLING, FULL, DRAINING};
  - read FSM enum {IDLE, DRAIN}.
- Sub-module `band_bank_ram`:
  - one 3x53x96 storage bank;
  - 1 write port (3 rows written together), 1 async read port (row, col);
  - instantiated twice.
- The collector holds the pointers, bank states, FSM and output register.

Test Plan:
- Band order:
  - Stimulus: one band of 53 tiles, tile k row r all bytes = (r*53 + k) mod 256, out_ready=1.
  - Response: 159 beats in raster order; out_last on beats 53, 106 and 159; first out_valid 2 cycles after the last in_valid; overflow=0.
- Backpressure:
  - Stimulus: same band, out_ready toggling 1/0 randomly, held 0 for 10 cycles mid-row.
  - Response: out_pixels stable while stalled; no beat lost or duplicated; 159 beats total.
- Ping-pong:
  - Stimulus: 2 bands back to back (106 consecutive in_valid), out_ready=1.
  - Response: band 1 drains while band 2 fills; 318 correct beats; overflow=0.
- Overflow:
  - Stimulus: out_ready=0, 3 bands back to back.
  - Response: overflow rises on the cycle after band 3 tile 0 and stays 1. Releasing out_ready yields bands 1 and 2 intact; the band-3 tiles are dropped and the bank is never filled (no out_valid for band 3).
- Frame end:
  - Stimulus: 160 bands, in_valid every 3rd cycle, out_ready=1.
  - Response: out_frame_end only on the final beat of band 160. A following band restarts rd_band at 0 and raises no out_frame_end until its 160th band.
- Reset mid-drain:
  - Stimulus: rst_n=0 for 1 cycle at beat 70 of a band.
  - Response: the next cycle shows all outputs 0 and overflow=0. A fresh band afterwards drains correctly starting at row 0, col 0.
